// File: rtl/branch_resolve_if.sv
// EX-stage control-flow bundle between the pipeline and branch_resolve.
// master drives EX/ID fields, slave returns redirect pulses, target and stall.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_jr;
    logic [5:0]      ex_opcode;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_pc_plus4;
    logic [XLEN-1:0] ex_imm;
    logic [25:0]     ex_joff;
    logic            ex_memread;
    logic [4:0]      ex_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            branchCheck;
    logic            JumpCheck;
    logic            JRCheck;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;

    modport master (
        output ex_valid, ex_branch, ex_jump, ex_jr, ex_opcode,
        output ex_rs1_val, ex_rs2_val, ex_pc_plus4, ex_imm, ex_joff,
        output ex_memread, ex_rd, id_rs1, id_rs2,
        input  branchCheck, JumpCheck, JRCheck, redirect_pc, stall
    );

    modport slave (
        input  ex_valid, ex_branch, ex_jump, ex_jr, ex_opcode,
        input  ex_rs1_val, ex_rs2_val, ex_pc_plus4, ex_imm, ex_joff,
        input  ex_memread, ex_rd, id_rs1, id_rs2,
        output branchCheck, JumpCheck, JRCheck, redirect_pc, stall
    );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolver with one-cycle flush shadow and load-use stall.
// Optional BR_PERF_EN adds saturating redirect and stall counters.
module branch_resolve #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    branch_resolve_if.slave bus
`ifdef BR_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stalls
`endif
);
    typedef enum logic {IDLE, SHADOW} state_t;

    state_t          state_q, state_d;
    logic            sel_jr, sel_j, sel_b, take, cond;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] joff_sext;
    logic            br_q, j_q, jr_q;
    logic [XLEN-1:0] pc_q;
    logic            stall_c;

    assign joff_sext = {{(XLEN-26){bus.ex_joff[25]}}, bus.ex_joff};

    always_comb begin
        cond = 1'b0;
        if (bus.ex_opcode == 6'h04)
            cond = (bus.ex_rs1_val == bus.ex_rs2_val);
        else if (bus.ex_opcode == 6'h05)
            cond = (bus.ex_rs1_val != '0);
    end

    always_comb begin
        state_d = state_q;
        sel_jr  = 1'b0;
        sel_j   = 1'b0;
        sel_b   = 1'b0;
        tgt     = '0;
        case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    if (bus.ex_jr) begin
                        sel_jr = 1'b1;
                        tgt    = bus.ex_rs1_val;
                    end else if (bus.ex_jump) begin
                        sel_j = 1'b1;
                        tgt   = bus.ex_pc_plus4 + joff_sext;
                    end else if (bus.ex_branch && cond) begin
                        sel_b = 1'b1;
                        tgt   = bus.ex_pc_plus4 + bus.ex_imm;
                    end
                end
                if (sel_jr || sel_j || sel_b)
                    state_d = SHADOW;
            end
            // EX holds a wrong-path instruction here; ignore it
            SHADOW:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign take = sel_jr | sel_j | sel_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            br_q    <= 1'b0;
            j_q     <= 1'b0;
            jr_q    <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            br_q    <= sel_b;
            j_q     <= sel_j;
            jr_q    <= sel_jr;
            pc_q    <= take ? tgt : '0;
        end
    end

    assign stall_c = bus.ex_valid & bus.ex_memread
                   & (bus.ex_rd != 5'd0)
                   & ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2))
                   & (state_q == IDLE);

    assign bus.branchCheck = br_q;
    assign bus.JumpCheck   = j_q;
    assign bus.JRCheck     = jr_q;
    assign bus.redirect_pc = pc_q;
    assign bus.stall       = stall_c;

`ifdef BR_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (take && perf_redirects != 32'hFFFFFFFF)
                perf_redirects <= perf_redirects + 32'd1;
            if (stall_c && perf_stalls != 32'hFFFFFFFF)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: branches, jumps, shadow, stall, reset.
// Build with +define+BR_PERF_EN to also cover the redirect counter.
module tb_branch_resolve;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_redir;

    branch_resolve_if #(.XLEN(32)) bus ();

`ifdef BR_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
    branch_resolve #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .perf_redirects(perf_redirects), .perf_stalls(perf_stalls)
    );
`else
    branch_resolve #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.ex_valid    = 1'b0;
        bus.ex_branch   = 1'b0;
        bus.ex_jump     = 1'b0;
        bus.ex_jr       = 1'b0;
        bus.ex_opcode   = 6'h00;
        bus.ex_rs1_val  = '0;
        bus.ex_rs2_val  = '0;
        bus.ex_pc_plus4 = '0;
        bus.ex_imm      = '0;
        bus.ex_joff     = '0;
        bus.ex_memread  = 1'b0;
        bus.ex_rd       = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        total++;
        if ({bus.branchCheck, bus.JumpCheck, bus.JRCheck} !== 3'b000) begin
            bad++;
            $display("FAIL reset_checks got=%b want=000",
                     {bus.branchCheck, bus.JumpCheck, bus.JRCheck});
        end
        total++;
        if (bus.redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc got=%h want=0", bus.redirect_pc);
        end
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%b want=0", bus.stall);
        end
`ifdef BR_PERF_EN
        total++;
        if (perf_redirects !== 32'h0 || perf_stalls !== 32'h0) begin
            bad++;
            $display("FAIL reset_perf got=%h/%h want=0/0",
                     perf_redirects, perf_stalls);
        end
`endif
        rst = 1'b0;
        exp_redir = 0;
    endtask

    task automatic test_beq();
        bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_opcode = 6'h04;
        bus.ex_rs1_val = 32'd5; bus.ex_rs2_val = 32'd5;
        bus.ex_pc_plus4 = 32'h100; bus.ex_imm = 32'h20;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.branchCheck !== 1'b1 || bus.redirect_pc !== 32'h120) begin
            bad++;
            $display("FAIL beq_taken got=%b/%h want=1/00000120",
                     bus.branchCheck, bus.redirect_pc);
        end
        total++;
        if (bus.JumpCheck !== 1'b0 || bus.JRCheck !== 1'b0) begin
            bad++;
            $display("FAIL beq_only got=%b%b want=00",
                     bus.JumpCheck, bus.JRCheck);
        end
        tick();
        total++;
        if (bus.branchCheck !== 1'b0) begin
            bad++;
            $display("FAIL beq_one_cycle got=%b want=0", bus.branchCheck);
        end
        bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_opcode = 6'h04;
        bus.ex_rs1_val = 32'd5; bus.ex_rs2_val = 32'd6;
        tick();
        idle_in();
        total++;
        if (bus.branchCheck !== 1'b0) begin
            bad++;
            $display("FAIL beq_not_taken got=%b want=0", bus.branchCheck);
        end
    endtask

    task automatic test_bnez();
        bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_opcode = 6'h05;
        bus.ex_rs1_val = 32'd0;
        tick();
        total++;
        if (bus.branchCheck !== 1'b0) begin
            bad++;
            $display("FAIL bnez_zero got=%b want=0", bus.branchCheck);
        end
        bus.ex_rs1_val = 32'd1; bus.ex_pc_plus4 = 32'h40;
        bus.ex_imm = 32'hFFFF_FFF0;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.branchCheck !== 1'b1 || bus.redirect_pc !== 32'h30) begin
            bad++;
            $display("FAIL bnez_taken got=%b/%h want=1/00000030",
                     bus.branchCheck, bus.redirect_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.ex_valid = 1'b1; bus.ex_jr = 1'b1; bus.ex_rs1_val = 32'h200;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.JRCheck !== 1'b1 || bus.redirect_pc !== 32'h200) begin
            bad++;
            $display("FAIL jr_taken got=%b/%h want=1/00000200",
                     bus.JRCheck, bus.redirect_pc);
        end
        bus.ex_valid = 1'b1; bus.ex_jump = 1'b1;
        bus.ex_pc_plus4 = 32'h1000; bus.ex_joff = 26'd4;
        tick();
        total++;
        if ({bus.branchCheck, bus.JumpCheck, bus.JRCheck} !== 3'b000) begin
            bad++;
            $display("FAIL shadow_discard got=%b want=000",
                     {bus.branchCheck, bus.JumpCheck, bus.JRCheck});
        end
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.JumpCheck !== 1'b1 || bus.redirect_pc !== 32'h1004) begin
            bad++;
            $display("FAIL j_after_shadow got=%b/%h want=1/00001004",
                     bus.JumpCheck, bus.redirect_pc);
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.ex_valid = 1'b1; bus.ex_jump = 1'b1;
        bus.ex_pc_plus4 = 32'h10; bus.ex_joff = 26'h3FF_FFFC;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.JumpCheck !== 1'b1 || bus.redirect_pc !== 32'hC) begin
            bad++;
            $display("FAIL j_negative got=%b/%h want=1/0000000c",
                     bus.JumpCheck, bus.redirect_pc);
        end
        tick();
        bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_opcode = 6'h04;
        bus.ex_pc_plus4 = 32'hFFFF_FFFC; bus.ex_imm = 32'h8;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.branchCheck !== 1'b1 || bus.redirect_pc !== 32'h4) begin
            bad++;
            $display("FAIL br_wrap got=%b/%h want=1/00000004",
                     bus.branchCheck, bus.redirect_pc);
        end
        tick();
    endtask

    task automatic test_priority();
        bus.ex_valid = 1'b1; bus.ex_jr = 1'b1; bus.ex_jump = 1'b1;
        bus.ex_branch = 1'b1; bus.ex_opcode = 6'h04;
        bus.ex_rs1_val = 32'h300; bus.ex_rs2_val = 32'h300;
        bus.ex_pc_plus4 = 32'h8; bus.ex_joff = 26'h40;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if ({bus.branchCheck, bus.JumpCheck, bus.JRCheck} !== 3'b001 ||
            bus.redirect_pc !== 32'h300) begin
            bad++;
            $display("FAIL prio_jr got=%b/%h want=001/00000300",
                     {bus.branchCheck, bus.JumpCheck, bus.JRCheck},
                     bus.redirect_pc);
        end
        tick();
        bus.ex_valid = 1'b1; bus.ex_jump = 1'b1; bus.ex_branch = 1'b1;
        bus.ex_opcode = 6'h04; bus.ex_pc_plus4 = 32'h20; bus.ex_joff = 26'h10;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if ({bus.branchCheck, bus.JumpCheck, bus.JRCheck} !== 3'b010 ||
            bus.redirect_pc !== 32'h30) begin
            bad++;
            $display("FAIL prio_j got=%b/%h want=010/00000030",
                     {bus.branchCheck, bus.JumpCheck, bus.JRCheck},
                     bus.redirect_pc);
        end
        tick();
        bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_opcode = 6'h06;
        tick();
        total++;
        if (bus.branchCheck !== 1'b0) begin
            bad++;
            $display("FAIL other_opcode got=%b want=0", bus.branchCheck);
        end
        idle_in();
        bus.ex_jr = 1'b1; bus.ex_rs1_val = 32'h44;
        tick();
        idle_in();
        total++;
        if (bus.JRCheck !== 1'b0) begin
            bad++;
            $display("FAIL bubble_jr got=%b want=0", bus.JRCheck);
        end
    endtask

    task automatic test_loaduse();
        bus.ex_valid = 1'b1; bus.ex_memread = 1'b1;
        bus.ex_rd = 5'd3; bus.id_rs2 = 5'd3;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_rs2 got=%b want=1", bus.stall);
        end
        bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL stall_rd0 got=%b want=0", bus.stall);
        end
        bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_rs1 got=%b want=1", bus.stall);
        end
        bus.id_rs1 = 5'd4;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL stall_nomatch got=%b want=0", bus.stall);
        end
        bus.id_rs2 = 5'd3; bus.ex_jr = 1'b1; bus.ex_rs1_val = 32'h80;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_with_jr got=%b want=1", bus.stall);
        end
        tick();
        bus.ex_jr = 1'b0;
        exp_redir++;
        #1;
        total++;
        if (bus.JRCheck !== 1'b1 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL stall_shadow got=jr%b/st%b want=jr1/st0",
                     bus.JRCheck, bus.stall);
        end
        tick();
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_after_shadow got=%b want=1", bus.stall);
        end
        idle_in();
        tick();
    endtask

    task automatic test_reset_shadow();
        bus.ex_valid = 1'b1; bus.ex_jr = 1'b1; bus.ex_rs1_val = 32'h400;
        tick();
        exp_redir++;
        total++;
        if (bus.JRCheck !== 1'b1 || bus.redirect_pc !== 32'h400) begin
            bad++;
            $display("FAIL rst_pre got=%b/%h want=1/00000400",
                     bus.JRCheck, bus.redirect_pc);
        end
`ifdef BR_PERF_EN
        total++;
        if (perf_redirects !== exp_redir) begin
            bad++;
            $display("FAIL perf_count got=%0d want=%0d",
                     perf_redirects, exp_redir);
        end
`endif
        rst = 1'b1;
        tick();
        idle_in();
        total++;
        if ({bus.branchCheck, bus.JumpCheck, bus.JRCheck} !== 3'b000 ||
            bus.redirect_pc !== 32'h0 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_shadow got=%b/%h/%b want=000/0/0",
                     {bus.branchCheck, bus.JumpCheck, bus.JRCheck},
                     bus.redirect_pc, bus.stall);
        end
        exp_redir = 0;
`ifdef BR_PERF_EN
        total++;
        if (perf_redirects !== 32'h0) begin
            bad++;
            $display("FAIL perf_rst got=%0d want=0", perf_redirects);
        end
`endif
        rst = 1'b0;
        bus.ex_valid = 1'b1; bus.ex_jr = 1'b1; bus.ex_rs1_val = 32'h500;
        tick();
        idle_in();
        exp_redir++;
        total++;
        if (bus.JRCheck !== 1'b1 || bus.redirect_pc !== 32'h500) begin
            bad++;
            $display("FAIL rst_recover got=%b/%h want=1/00000500",
                     bus.JRCheck, bus.redirect_pc);
        end
        tick();
`ifdef BR_PERF_EN
        total++;
        if (perf_redirects !== exp_redir) begin
            bad++;
            $display("FAIL perf_after_rst got=%0d want=%0d",
                     perf_redirects, exp_redir);
        end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_redir = 0;
        rst = 1'b1;
        idle_in();
        test_reset();
        test_beq();
        test_bnez();
        test_back_to_back();
        test_wrap();
        test_priority();
        test_loaduse();
        test_reset_shadow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
